bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stage.
- Accepts a parallel word through a LOAD/READY handshake and shifts it out one bit at a time on E. E drives the detector's serial input directly.
- Each bit is held for a programmable number of clocks, so patterns such as 1-1-0-1 can be presented to the detector deterministically.
- A one-cycle DONE pulse marks the end of each word.

Parameters:
- WIDTH, 8, number of bits per word (legal range 2..32).
- DIV, 1, clocks per bit period. Legal range 1..255. DIV=0 is rejected at elaboration.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- CLK  input  1  single system clock; all logic is on the rising edge.
- RST  input  1  synchronous reset, active-high.
- DIN  input  WIDTH  parallel word; sampled only on an accepted LOAD.
- LOAD  input  1  load request; accepted only when READY=1.
- READY  output  1  high in IDLE; block can accept a word.
- E  output  WIDTH-independent 1  registered serial bit to the detector.
- BIT_VALID  output  1  high while E carries a data bit.
- DONE  output  1  one-cycle pulse after the last bit period.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high. All outputs are registered.
- Reset values: READY=1, E=0, BIT_VALID=0, DONE=0. State=IDLE, shift register=0, counters=0.
- RST has priority over every other input. Asserting RST mid-word aborts the word: the next cycle is IDLE, and no DONE pulse is produced.
- IDLE:
  - READY=1, E=0, BIT_VALID=0.
  - On LOAD=1: capture DIN into the shift register, clear the bit counter and DIV counter, and go to SHIFT.
- SHIFT:
  - READY=0, BIT_VALID=1.
  - E = current head bit: shreg[WIDTH-1] if MSB_FIRST=1, else shreg[0].
  - The DIV counter counts 0..DIV-1. At DIV-1 the shift register shifts (zero fill) and the bit counter increments.
  - When the bit counter reaches WIDTH-1 and the DIV counter reaches DIV-1, go to FIN.
- FIN:
  - One cycle only: DONE=1, E=0, BIT_VALID=0, READY=0.
  - Then return to IDLE.
- Timing, with LOAD accepted at the edge ending cycle t:
  - Bit k appears on E during cycles t+1+k*DIV through t+(k+1)*DIV.
  - DONE is high in cycle t+1+WIDTH*DIV.
  - READY returns high in cycle t+2+WIDTH*DIV.
- LOAD while READY=0 is ignored. DIN changes outside IDLE have no effect.
- LOAD held high continuously yields back-to-back words separated by one FIN cycle plus one IDLE cycle. E=0 during both of those cycles.
- Counter widths: bit counter $clog2(WIDTH); DIV counter $clog2(DIV+1). Neither counter ever wraps past its terminal value.
- State encoding: 2 bits, IDLE=0, SHIFT=1, FIN=2. The unused code 3 returns to IDLE on the next clock with all outputs at their reset values.

Decomposition:
- Shared header holds the state localparams ST_IDLE, ST_SHIFT and ST_FIN, and the DIV legality check macro.
- Sub-module bit_tick_div:
  - Parameterised DIV counter with inputs CLK, RST and CLR, and output TICK, asserted on the terminal count.
  - The serializer instantiates one.
- The shift register, bit counter and FSM stay in bit_serializer.

Test Plan:
- Reset: RST=1 for 2 cycles with LOAD=1 and DIN=all ones -> READY=1, E=0, BIT_VALID=0, DONE=0 throughout, and no load occurs.
- WIDTH=4, DIV=1, MSB_FIRST=1, DIN=4'b1101, LOAD pulsed at t:
  - E=1,1,0,1 in cycles t+1..t+4, with BIT_VALID high in exactly those cycles.
  - DONE high in t+5 only; READY high again in t+6.
  - A downstream sequence detector asserts Y in cycle t+4.
- Same word with DIV=3 -> each bit is held exactly 3 cycles (E=1 for t+1..t+6, 0 for t+7..t+9, 1 for t+10..t+12). DONE at t+13.
- MSB_FIRST=0, DIN=4'b1011 -> E=1,1,0,1 (LSB first). Same timing as the second scenario.
- LOAD re-asserted during SHIFT with a different DIN -> ignored; the original word completes unchanged and exactly one DONE pulse occurs.
- RST asserted during bit 2 of a word -> the next cycle has E=0, READY=1, no DONE. A new LOAD on the following cycle serializes correctly from bit 0.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: FSM state codes and parameter legality check shared by the serializer slice
package bit_serializer_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;
endpackage

`ifndef BIT_SER_DIV_CHECK
`define BIT_SER_DIV_CHECK(d) if ((d) < 1 || (d) > 255) begin : g_div_chk $error("bit_serializer: DIV must be 1..255"); end
`endif

// File: rtl/bit_tick_div.sv
// bit_tick_div: counts 0..DIV-1 while CLR is low; TICK marks the terminal count (ports CLK, RST, CLR, TICK)
module bit_tick_div #(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);
  localparam int CW = $clog2(DIV + 1);
  logic [CW-1:0] cnt;
  assign TICK = cnt == CW'(DIV - 1);
  always_ff @(posedge CLK)
    cnt <= (RST || CLR || TICK) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: LOAD/READY word capture shifted out on E, DIV clocks per bit, DONE pulse per word
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             E,
  output logic             BIT_VALID,
  output logic             DONE
);
  localparam int BW = $clog2(WIDTH);
  `BIT_SER_DIV_CHECK(DIV)
  if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
    $error("bit_serializer: WIDTH must be 2..32");
  end
  logic [1:0] state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0] bit_cnt;
  logic tick;
  logic last;
  function automatic logic head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction
  bit_tick_div #(.DIV(DIV)) u_div (
    .CLK (CLK),
    .RST (RST),
    .CLR (state != ST_SHIFT),
    .TICK(tick)
  );
  assign shifted = (MSB_FIRST != 0) ? shreg << 1 : shreg >> 1;
  assign last    = tick && bit_cnt == BW'(WIDTH - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      READY     <= 1'b1;
      E         <= 1'b0;
      BIT_VALID <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (LOAD) begin
          state     <= ST_SHIFT;
          shreg     <= DIN;
          bit_cnt   <= '0;
          READY     <= 1'b0;
          E         <= head(DIN);
          BIT_VALID <= 1'b1;
        end
        ST_SHIFT: if (last) begin
          state     <= ST_FIN;
          shreg     <= shifted;
          bit_cnt   <= '0;
          E         <= 1'b0;
          BIT_VALID <= 1'b0;
          DONE      <= 1'b1;
        end else if (tick) begin
          shreg   <= shifted;
          bit_cnt <= bit_cnt + 1'b1;
          E       <= head(shifted);
        end
        ST_FIN: begin
          state <= ST_IDLE;
          DONE  <= 1'b0;
          READY <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          shreg     <= '0;
          bit_cnt   <= '0;
          READY     <= 1'b1;
          E         <= 1'b0;
          BIT_VALID <= 1'b0;
          DONE      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized and directed checks of four serializer configurations against a timing model
module tb_bit_serializer;
  localparam int N = 4;
  localparam int WS[N] = '{4, 4, 4, 8};
  localparam int DS[N] = '{1, 3, 3, 2};
  localparam int MS[N] = '{1, 1, 0, 0};
  localparam int LEN = 18;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b1;
  logic [7:0] din = 8'hff;
  logic [N-1:0] ready, e, bv, done;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    bit_serializer #(.WIDTH(WS[g]), .DIV(DS[g]), .MSB_FIRST(MS[g])) u_dut (
      .CLK      (clk),
      .RST      (rst),
      .DIN      (din[WS[g]-1:0]),
      .LOAD     (load),
      .READY    (ready[g]),
      .E        (e[g]),
      .BIT_VALID(bv[g]),
      .DONE     (done[g])
    );
  end
  function automatic logic [3:0] model(input int g, input int p, input logic [7:0] w);
    int n = WS[g] * DS[g];
    int k = (p - 1) / DS[g];
    if (p <= n) return {w[(MS[g] != 0) ? WS[g] - 1 - k : k], 3'b100};
    if (p == n + 1) return 4'b0010;
    return 4'b0001;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      for (int g = 0; g < N; g++) begin
        tests++;
        if ({e[g], bv[g], done[g], ready[g]} !== 4'b0001) begin
          fails++;
          $display("FAIL reset dut%0d cycle %0d: {E,BV,DONE,READY} got %b want 0001", g, c, {e[g], bv[g], done[g], ready[g]});
        end
      end
      if (c == 1) begin
        rst = 1'b0;
        load = 1'b0;
      end
    end
  endtask
  task automatic test_word(input logic [7:0] w);
    din = w;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int p = 1; p <= LEN; p++) begin
      for (int g = 0; g < N; g++) begin
        tests++;
        if ({e[g], bv[g], done[g], ready[g]} !== model(g, p, w)) begin
          fails++;
          $display("FAIL word %h dut%0d cycle t+%0d: got %b want %b", w, g, p, {e[g], bv[g], done[g], ready[g]}, model(g, p, w));
        end
      end
      step();
    end
  endtask
  task automatic test_load_ignored(input logic [7:0] w);
    int dcnt[N] = '{0, 0, 0, 0};
    din = w;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int p = 1; p <= LEN; p++) begin
      if (p == 2) begin
        load = 1'b1;
        din = ~w;
      end else begin
        load = 1'b0;
        din = 8'($urandom);
      end
      for (int g = 0; g < N; g++) begin
        dcnt[g] += int'(done[g]);
        tests++;
        if ({e[g], bv[g], done[g], ready[g]} !== model(g, p, w)) begin
          fails++;
          $display("FAIL load_ignored dut%0d cycle t+%0d: got %b want %b", g, p, {e[g], bv[g], done[g], ready[g]}, model(g, p, w));
        end
      end
      step();
    end
    load = 1'b0;
    for (int g = 0; g < N; g++) begin
      tests++;
      if (dcnt[g] != 1) begin
        fails++;
        $display("FAIL done_count dut%0d: got %0d pulses want 1", g, dcnt[g]);
      end
    end
  endtask
  task automatic test_reset_midword(input logic [7:0] w, input logic [7:0] w2);
    din = w;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      for (int g = 0; g < N; g++) begin
        tests++;
        if ({e[g], bv[g], done[g], ready[g]} !== model(g, p, w)) begin
          fails++;
          $display("FAIL pre_abort dut%0d cycle t+%0d: got %b want %b", g, p, {e[g], bv[g], done[g], ready[g]}, model(g, p, w));
        end
      end
      if (p < 3) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int g = 0; g < N; g++) begin
      tests++;
      if ({e[g], bv[g], done[g], ready[g]} !== 4'b0001) begin
        fails++;
        $display("FAIL abort dut%0d: got %b want 0001", g, {e[g], bv[g], done[g], ready[g]});
      end
    end
    test_word(w2);
  endtask
  task automatic test_back_to_back(input logic [7:0] w);
    din = w;
    load = 1'b1;
    step();
    for (int p = 1; p <= 40; p++) begin
      for (int g = 0; g < N; g++) begin
        int ph = ((p - 1) % (WS[g] * DS[g] + 2)) + 1;
        tests++;
        if ({e[g], bv[g], done[g], ready[g]} !== model(g, ph, w)) begin
          fails++;
          $display("FAIL back_to_back dut%0d cycle t+%0d: got %b want %b", g, p, {e[g], bv[g], done[g], ready[g]}, model(g, ph, w));
        end
      end
      step();
    end
    load = 1'b0;
    repeat (LEN + 2) step();
    for (int g = 0; g < N; g++) begin
      tests++;
      if ({e[g], bv[g], done[g], ready[g]} !== 4'b0001) begin
        fails++;
        $display("FAIL drain dut%0d: got %b want 0001", g, {e[g], bv[g], done[g], ready[g]});
      end
    end
  endtask
  initial begin
    test_reset();
    test_word(8'h0d);
    test_word(8'h0b);
    for (int i = 0; i < 6; i++) test_word(8'($urandom));
    test_load_ignored(8'($urandom));
    test_reset_midword(8'h0d, 8'($urandom));
    test_back_to_back(8'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
